// File: rtl/uart_cmd_initiator_pkg.sv
// Shared protocol constants and state encodings for the PC<->board UART command link.
// Also used by the board-side controller.
package uart_cmd_initiator_pkg;

  localparam logic [7:0] PROT_PC_B_RESET       = 8'h00;
  localparam logic [7:0] PROT_PC_B_SEND_CONFIG = 8'h01;
  localparam logic [7:0] PROT_PC_B_CLOCK       = 8'h02;
  localparam logic [7:0] PROT_B_PC_SEND_DATA   = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TX_ISSUE  = 3'd1,
    ST_TX_ACK    = 3'd2,
    ST_TX_DRAIN  = 3'd3,
    ST_WAIT_RESP = 3'd4
  } state_e;

  // Command-level phase of the initiator; byte handshakes live in uart_cmd_tx_seq.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_OP   = 2'd1,
    PH_CFG  = 2'd2,
    PH_WAIT = 2'd3
  } phase_e;

  function automatic logic op_legal(input logic [7:0] op);
    return op <= PROT_PC_B_CLOCK;
  endfunction

endpackage

// File: rtl/uart_cmd_tx_seq.sv
// Byte handshake towards a uart_tx-style transmitter: issue, wait for busy, wait for drain.
// A start request during the drain-complete cycle chains the next byte without idling.
module uart_cmd_tx_seq
  import uart_cmd_initiator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_done_c,
  output logic       o_tx_trig,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_bsy
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic       r_tx_trig;
  logic [7:0] r_tx_data;
  logic       w_done;
  logic       w_load;
  logic       w_trig;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (i_start)   w_state_nxt = ST_TX_ISSUE;
      ST_TX_ISSUE: if (!i_tx_bsy) w_state_nxt = ST_TX_ACK;
      ST_TX_ACK:   if (i_tx_bsy)  w_state_nxt = ST_TX_DRAIN;
      ST_TX_DRAIN: if (!i_tx_bsy) w_state_nxt = i_start ? ST_TX_ISSUE : ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_done = 1'b0;
    w_load = 1'b0;
    w_trig = 1'b0;
    w_done = (r_state == ST_TX_DRAIN) && !i_tx_bsy;
    w_load = i_start && ((r_state == ST_IDLE) || w_done);
    w_trig = (r_state == ST_TX_ISSUE) && !i_tx_bsy;
  end

  // tx_data only changes on a new load, so it is stable for the whole frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_trig <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_tx_trig <= w_trig;
      if (w_load) r_tx_data <= i_byte;
    end
  end

  assign o_done_c  = w_done;
  assign o_tx_trig = r_tx_trig;
  assign o_tx_data = r_tx_data;

endmodule

// File: rtl/uart_cmd_initiator.sv
// Host-side command initiator: serializes RESET / SEND_CONFIG / CLOCK commands to a UART
// transmitter and captures the single CLOCK response byte with a timeout.
module uart_cmd_initiator
  import uart_cmd_initiator_pkg::*;
#(
  parameter int unsigned CFG_BYTES    = 4,
  parameter int unsigned RESP_TIMEOUT = 2700,
  parameter int unsigned TMO_BITS     = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_op,
  input  logic [CFG_BYTES*8-1:0] cmd_cfg,
  output logic                   tx_trig,
  output logic [7:0]             tx_data,
  input  logic                   tx_bsy,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   resp_valid,
  output logic [7:0]             resp_data,
  output logic                   resp_timeout,
  output logic                   cmd_err,
  output logic                   busy
);

  localparam int unsigned CFG_W = CFG_BYTES * 8;
  localparam int unsigned IDX_W = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(CFG_BYTES - 1);
  localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(RESP_TIMEOUT - 1);

  phase_e              r_phase;
  phase_e              w_phase_nxt;
  logic [7:0]          r_op;
  logic [CFG_W-1:0]    r_cfg;
  logic [IDX_W-1:0]    r_idx;
  logic [TMO_BITS-1:0] r_tmo;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_resp_valid;
  logic [7:0]          r_resp_data;
  logic                r_resp_timeout;
  logic                r_cmd_err;

  logic       w_accept;
  logic       w_legal;
  logic       w_done;
  logic       w_last;
  logic       w_expire;
  logic       w_start;
  logic [7:0] w_byte;
  logic       w_resp_valid;
  logic       w_resp_timeout;
  logic       w_cmd_err;

  assign w_accept = cmd_valid && (r_phase == PH_IDLE);
  assign w_legal  = op_legal(cmd_op);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_expire = (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) r_phase <= PH_IDLE;
    else      r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_IDLE: if (w_accept && w_legal) w_phase_nxt = PH_OP;
      PH_OP: begin
        if (w_done) begin
          if (r_op == PROT_PC_B_SEND_CONFIG)  w_phase_nxt = PH_CFG;
          else if (r_op == PROT_PC_B_CLOCK)   w_phase_nxt = PH_WAIT;
          else                                w_phase_nxt = PH_IDLE;
        end
      end
      PH_CFG:  if (w_done && w_last)        w_phase_nxt = PH_IDLE;
      PH_WAIT: if (rx_valid || w_expire)    w_phase_nxt = PH_IDLE;
      default:                              w_phase_nxt = PH_IDLE;
    endcase
  end

  // Payload always comes from r_cfg[7:0]; r_cfg shifts down one byte per load (LSB byte first).
  always_comb begin
    w_start        = 1'b0;
    w_byte         = r_cfg[7:0];
    w_resp_valid   = 1'b0;
    w_resp_timeout = 1'b0;
    w_cmd_err      = 1'b0;
    case (r_phase)
      PH_IDLE: begin
        w_start   = w_accept && w_legal;
        w_byte    = cmd_op;
        w_cmd_err = w_accept && !w_legal;
      end
      PH_OP:   w_start = w_done && (r_op == PROT_PC_B_SEND_CONFIG);
      PH_CFG:  w_start = w_done && !w_last;
      PH_WAIT: begin
        w_resp_valid   = rx_valid;
        w_resp_timeout = !rx_valid && w_expire;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op           <= 8'h00;
      r_cfg          <= '0;
      r_idx          <= '0;
      r_tmo          <= '0;
      r_cmd_ready    <= 1'b1;
      r_busy         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= 8'h00;
      r_resp_timeout <= 1'b0;
      r_cmd_err      <= 1'b0;
    end else begin
      r_cmd_ready    <= (w_phase_nxt == PH_IDLE);
      r_busy         <= (w_phase_nxt != PH_IDLE);
      r_resp_valid   <= w_resp_valid;
      r_resp_timeout <= w_resp_timeout;
      r_cmd_err      <= w_cmd_err;
      if (w_resp_valid) r_resp_data <= rx_data;
      if (w_accept) begin
        r_op  <= cmd_op;
        r_cfg <= cmd_cfg;
        r_idx <= '0;
      end else if (w_start) begin
        r_cfg <= r_cfg >> 8;
        if (r_phase == PH_CFG) r_idx <= r_idx + IDX_W'(1);
      end
      r_tmo <= (r_phase == PH_WAIT) ? r_tmo + TMO_BITS'(1) : '0;
    end
  end

  uart_cmd_tx_seq u_tx_seq (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_byte    (w_byte),
    .o_done_c  (w_done),
    .o_tx_trig (tx_trig),
    .o_tx_data (tx_data),
    .i_tx_bsy  (tx_bsy)
  );

  assign cmd_ready    = r_cmd_ready;
  assign busy         = r_busy;
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign resp_timeout = r_resp_timeout;
  assign cmd_err      = r_cmd_err;

endmodule
